// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA pushes bytes into a FIFO that is sent LSB first, with one start and one stop bit.
// Latency: a write at edge N makes count=1 after N. The head byte is popped at N+1, and o_uart_tx falls after N+1.
// Backpressure: none toward the core. A write while full is dropped and sets the sticky ovf flag; software polls STATUS.
//
// Ports: clk / reset_n (async, active-low); i_mem_addr, i_mem_wr_en, i_mem_wr_data from the data-memory bus;
//        o_sel (address hits TXDATA or STATUS), o_rd_data (STATUS word, else 0), o_uart_tx (serial line, idles high).
// Build option: define MMIO_UART_PARITY_EN to add an even-parity bit after bit 7 (11-bit frames).
// STATUS word: bit0 busy, bit1 full, bit2 ovf, bits 15:8 FIFO count, all other bits 0.
module mmio_uart_tx #(
    parameter int                           DATA_WIDTH_P      = 32,
    parameter int                           DATA_ADDR_WIDTH_P = 32,
    parameter logic [DATA_ADDR_WIDTH_P-1:0] BASE_ADDR_P       = 32'h0000_0100,
    parameter int                           CLKS_PER_BIT_P    = 217,
    parameter int                           FIFO_DEPTH_P      = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DATA_ADDR_WIDTH_P-1:0] i_mem_addr,
    input  logic                         i_mem_wr_en,
    input  logic [DATA_WIDTH_P-1:0]      i_mem_wr_data,
    output logic                         o_sel,
    output logic [DATA_WIDTH_P-1:0]      o_rd_data,
    output logic                         o_uart_tx
);

    localparam int TW = $clog2(CLKS_PER_BIT_P);
    localparam int PW = $clog2(FIFO_DEPTH_P);
    localparam int CW = $clog2(FIFO_DEPTH_P + 1);

    localparam logic [TW-1:0]                T_LAST    = TW'(CLKS_PER_BIT_P - 1);
    localparam logic [CW-1:0]                DEPTH_C   = CW'(FIFO_DEPTH_P);
    localparam logic [DATA_ADDR_WIDTH_P-1:0] STAT_ADDR = BASE_ADDR_P + DATA_ADDR_WIDTH_P'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef MMIO_UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Address decode and bus strobes
    logic sel_tx;
    logic sel_st;
    logic push_req;
    logic clr_ovf;

    assign sel_tx   = (i_mem_addr == BASE_ADDR_P);
    assign sel_st   = (i_mem_addr == STAT_ADDR);
    assign o_sel    = sel_tx | sel_st;
    assign push_req = i_mem_wr_en & sel_tx;
    assign clr_ovf  = i_mem_wr_en & sel_st;

    // Only the low byte of a TXDATA write is meaningful.
    logic unused_wr_hi;
    assign unused_wr_hi = ^i_mem_wr_data[DATA_WIDTH_P-1:8];

    // Transmit FIFO
    logic [7:0]    mem [FIFO_DEPTH_P];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_ok;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          bit_done;
`ifdef MMIO_UART_PARITY_EN
    logic          par_bit;
`endif

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign pop      = (state == S_IDLE) && !empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push_ok  = push_req && (!full || pop);
    assign bit_done = (timer == T_LAST);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_mem_wr_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (clr_ovf) begin
                ovf <= 1'b0;
            end else if (push_req && !push_ok) begin
                ovf <= 1'b1;
            end
        end
    end

    // Serialiser. o_uart_tx is registered and loaded on each transition, so the line changes on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            idx       <= '0;
            shift     <= '0;
            o_uart_tx <= 1'b1;
`ifdef MMIO_UART_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    o_uart_tx <= 1'b1;
                    timer     <= '0;
                    if (pop) begin
                        shift     <= mem[rd_ptr];
`ifdef MMIO_UART_PARITY_EN
                        par_bit   <= ^mem[rd_ptr];
`endif
                        state     <= S_START;
                        o_uart_tx <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        timer     <= '0;
                        idx       <= '0;
                        state     <= S_DATA;
                        o_uart_tx <= shift[0];
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (idx == 3'd7) begin
                            idx       <= '0;
`ifdef MMIO_UART_PARITY_EN
                            state     <= S_PARITY;
                            o_uart_tx <= par_bit;
`else
                            state     <= S_STOP;
                            o_uart_tx <= 1'b1;
`endif
                        end else begin
                            // The next bit is shift[1] now and shift[0] after the shift.
                            shift     <= shift >> 1;
                            idx       <= idx + 3'd1;
                            o_uart_tx <= shift[1];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
`ifdef MMIO_UART_PARITY_EN
                S_PARITY: begin
                    if (bit_done) begin
                        timer     <= '0;
                        state     <= S_STOP;
                        o_uart_tx <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_done) begin
                        timer     <= '0;
                        state     <= S_IDLE;
                        o_uart_tx <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    timer     <= '0;
                    o_uart_tx <= 1'b1;
                end
            endcase
        end
    end

    // STATUS read path (combinational, no side effects)
    logic [DATA_WIDTH_P-1:0] status;

    always_comb begin
        status       = '0;
        status[0]    = (state != S_IDLE) || !empty;
        status[1]    = full;
        status[2]    = ovf;
        status[15:8] = 8'(count);
    end

    assign o_rd_data = sel_st ? status : '0;

endmodule
